bsg_link_sdr_upstream: RTL and testbench
========================================

BSG_LINK_SDR_UPSTREAM -- requirements
Module: bsg_link_sdr_upstream

Interface
REQ-001 Parameter width_p, default 32: core word width in bits.
REQ-002 Parameter channel_width_p, default 8: io beat width; width_p SHALL be an integer multiple of it.
REQ-003 Parameter lg_fifo_depth_p, default 5: log2 of the receiver buffer depth in words; initial credits = 2^lg_fifo_depth_p.
REQ-004 Parameter lg_credit_to_token_decimation_p, default 2: each token toggle returns 2^this credits.
REQ-005 clk  in  1  sole clock; all state on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 core_data_i  in  width_p  word offered by core.
REQ-008 core_valid_i  in  1  core word valid.
REQ-009 core_ready_o  out  1  block can accept a word; transfer = valid & ready.
REQ-010 io_data_o  out  channel_width_p  current beat, least-significant slice first.
REQ-011 io_valid_o  out  1  io_data_o carries a beat.
REQ-012 token_i  in  1  credit-return toggle from the downstream receiver (asynchronous to clk).
REQ-013 credit_o  out  lg_fifo_depth_p+1  current credit count (debug/verification).
REQ-014 credit_err_o  out  1  sticky: a token return would exceed maximum credits.

Function
REQ-015 Input SHALL be a 2-entry FIFO; core_ready_o = FIFO not full; core_ready_o SHALL NOT depend combinationally on core_valid_i.
REQ-016 token_i SHALL pass a 2-flop synchronizer; a token event = synchronized value differs from its registered previous value (either edge).
REQ-017 FSM states IDLE and SEND; beat counter width clog2(width_p/channel_width_p).
REQ-018 IDLE -> SEND when FIFO non-empty and credit_o > 0: dequeue word into shift register, decrement credit, beat counter = 0.
REQ-019 In SEND, io_valid_o = 1 and io_data_o = shift register low slice; each cycle shift right by channel_width_p and increment beat counter.
REQ-020 On last beat: if FIFO non-empty and credit > 0 (after this cycle's token increment), load next word and stay in SEND (no bubble); else -> IDLE.
REQ-021 Word latency: word accepted at cycle t into empty FIFO with credit emits beat 0 at cycle t+2, last beat at t+1+width_p/channel_width_p.
REQ-022 io_valid_o SHALL be 0 in IDLE; io_data_o SHALL be 0 when io_valid_o = 0.
REQ-023 Credit update per cycle: credit + (token event ? 2^lg_credit_to_token_decimation_p : 0) - (word load ? 1 : 0), both applied in same cycle.
REQ-024 If the sum exceeds 2^lg_fifo_depth_p, credit SHALL saturate at maximum and credit_err_o SHALL set and hold until reset.
REQ-025 With credit_o = 0 no word is loaded; FIFO fills, core_ready_o drops after 2 accepted words.
REQ-026 Enqueue and dequeue in the same cycle on a full FIFO SHALL NOT be allowed (ready is registered full flag); on non-full FIFO both proceed.

Reset
REQ-027 While rst_n = 0: state IDLE, FIFO empty, core_ready_o = 0, io_valid_o = 0, io_data_o = 0, credit_o = 2^lg_fifo_depth_p, credit_err_o = 0, synchronizer flops = 0.
REQ-028 Reset asserted mid-word SHALL drop the partial word immediately (asynchronously); no remaining beats emitted.
REQ-029 core_ready_o SHALL rise on the first clk edge after rst_n deasserts.

Structure
REQ-030 Shared package bsg_link_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-031 Input FIFO SHALL be the sub-module bsg_two_fifo; synchronizer, FSM, shift register and credit counter are in this module.

Verification
REQ-032 Single word 32'hA1B2C3D4 after reset, credit 32 -> io_data_o D4, C3, B2, A1 on 4 consecutive cycles starting t+2; credit_o = 31.
REQ-033 Three words back-to-back -> 12 consecutive valid beats, no bubble; credit_o = 29.
REQ-034 33 words, no tokens -> 32 words emitted, 33rd held; core_ready_o low once FIFO full; one token toggle -> credit 4, 33rd word sent, credit 3.
REQ-035 Token toggle arriving in the same cycle as a word load with credit 1 -> credit 1+4-1 = 4.
REQ-036 One token toggle at full credit 32 -> credit_o stays 32, credit_err_o = 1 and stays 1.
REQ-037 rst_n pulsed low after beat 1 of a word -> io_valid_o falls immediately, credit_o = 32, FIFO empty, no further beats.

Source files
------------

// File: rtl/bsg_link_pkg.sv
// Shared definitions for the SDR link: FSM state encoding and default sizing.
package bsg_link_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } link_state_e;

  localparam int LINK_WIDTH_DEF        = 32;
  localparam int LINK_CHANNEL_DEF      = 8;
  localparam int LINK_LG_FIFO_DEF      = 5;
  localparam int LINK_LG_DECIMATE_DEF  = 2;

endpackage

// File: rtl/bsg_link_sdr_upstream_if.sv
// Core-side word handshake plus io-side beat stream of the SDR upstream link.
interface bsg_link_sdr_upstream_if #(
  parameter int width_p         = 32,
  parameter int channel_width_p = 8
);
  logic [width_p-1:0]         core_data_i;
  logic                       core_valid_i;
  logic                       core_ready_o;
  logic [channel_width_p-1:0] io_data_o;
  logic                       io_valid_o;

  modport slave (
    input  core_data_i, core_valid_i,
    output core_ready_o, io_data_o, io_valid_o
  );

  modport master (
    output core_data_i, core_valid_i,
    input  core_ready_o, io_data_o, io_valid_o
  );
endinterface

// File: rtl/bsg_two_fifo.sv
// Two-entry input FIFO; ready is a registered not-full flag so it never
// depends combinationally on the producer's valid.
module bsg_two_fifo
  import bsg_link_pkg::*;
#(
  parameter int width_p = LINK_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_r [2];
  logic               wptr_r, rptr_r;
  logic [1:0]         count_r, count_next;
  logic               enq, deq;

  always_comb begin
    enq        = v_i & ready_o;
    deq        = yumi_i & v_o;
    count_next = count_r + {1'b0, enq} - {1'b0, deq};
    v_o        = (count_r != 2'd0);
    data_o     = mem_r[rptr_r];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      count_r <= 2'd0;
      ready_o <= 1'b0;
    end else begin
      wptr_r  <= wptr_r ^ enq;
      rptr_r  <= rptr_r ^ deq;
      count_r <= count_next;
      ready_o <= (count_next != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_link_sdr_upstream.sv
// SDR link upstream: serializes core words into channel-wide beats, LSB slice
// first, gated by a credit counter replenished through a toggling token line.
module bsg_link_sdr_upstream
  import bsg_link_pkg::*;
#(
  parameter int width_p                         = LINK_WIDTH_DEF,
  parameter int channel_width_p                 = LINK_CHANNEL_DEF,
  parameter int lg_fifo_depth_p                 = LINK_LG_FIFO_DEF,
  parameter int lg_credit_to_token_decimation_p = LINK_LG_DECIMATE_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bsg_link_sdr_upstream_if.slave   link,
  input  logic                     token_i,
  output logic [lg_fifo_depth_p:0] credit_o,
  output logic                     credit_err_o
);

  localparam int BEATS = width_p / channel_width_p;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CRW   = lg_fifo_depth_p + 1;
  localparam int SW    = lg_fifo_depth_p + 3;
  localparam int MAXC  = 2 ** lg_fifo_depth_p;
  localparam int INC   = 2 ** lg_credit_to_token_decimation_p;

  // Sum may exceed the credit range only on an over-returned token.
  function automatic logic [CRW-1:0] sat_credit(input logic [SW-1:0] sum);
    return (sum > SW'(MAXC)) ? CRW'(MAXC) : sum[CRW-1:0];
  endfunction

  link_state_e          state_r;
  logic [BW-1:0]        beat_r;
  logic [width_p-1:0]   shift_r;
  logic [CRW-1:0]       credit_r;
  logic                 err_r;
  logic                 sync_p0, sync_p1, tok_prev;

  logic [width_p-1:0]   fifo_data;
  logic                 fifo_v, fifo_ready;
  logic                 tok_evt, last_beat, load;
  logic [SW-1:0]        avail, sum;

  bsg_two_fifo #(.width_p(width_p)) fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (link.core_data_i),
    .v_i    (link.core_valid_i),
    .ready_o(fifo_ready),
    .data_o (fifo_data),
    .v_o    (fifo_v),
    .yumi_i (load)
  );

  always_comb begin
    tok_evt   = sync_p1 ^ tok_prev;
    avail     = SW'(credit_r) + (tok_evt ? SW'(INC) : SW'(0));
    last_beat = (beat_r == BW'(BEATS - 1));
    load      = ((state_r == ST_IDLE) || last_beat) && fifo_v && (avail != SW'(0));
    sum       = avail - SW'(load);
  end

  // Token synchronizer: two flops, then an edge detector against the previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      tok_prev <= 1'b0;
    end else begin
      sync_p0  <= token_i;
      sync_p1  <= sync_p0;
      tok_prev <= sync_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      beat_r   <= '0;
      credit_r <= CRW'(MAXC);
      err_r    <= 1'b0;
    end else begin
      credit_r <= sat_credit(sum);
      if (sum > SW'(MAXC)) err_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (load) begin
            state_r <= ST_SEND;
            beat_r  <= '0;
          end
        end
        default: begin
          if (!last_beat)  beat_r  <= beat_r + BW'(1);
          else if (load)   beat_r  <= '0;
          else             state_r <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (load)                     shift_r <= fifo_data;
    else if (state_r == ST_SEND)  shift_r <= shift_r >> channel_width_p;
  end

  assign link.core_ready_o = fifo_ready;
  assign link.io_valid_o   = (state_r == ST_SEND);
  assign link.io_data_o    = (state_r == ST_SEND) ? shift_r[channel_width_p-1:0] : '0;
  assign credit_o          = credit_r;
  assign credit_err_o      = err_r;

endmodule

// File: tb/tb_bsg_link_sdr_upstream.sv
// Directed bench for bsg_link_sdr_upstream: latency, streaming, credit flow and reset.
module tb_bsg_link_sdr_upstream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       token;
  logic [5:0] credit;
  logic       credit_err;
  int         checks = 0;
  int         errors = 0;
  int         beat_cnt = 0;

  bsg_link_sdr_upstream_if #(.width_p(32), .channel_width_p(8)) lif ();

  bsg_link_sdr_upstream #(
    .width_p(32), .channel_width_p(8), .lg_fifo_depth_p(5), .lg_credit_to_token_decimation_p(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .link        (lif.slave),
    .token_i     (token),
    .credit_o    (credit),
    .credit_err_o(credit_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (lif.io_valid_o === 1'b1) beat_cnt <= beat_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    token = 1'b0;
    lif.core_valid_i = 1'b0;
    lif.core_data_i  = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    lif.core_data_i  = w;
    lif.core_valid_i = 1'b1;
    while (lif.core_ready_o !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    if (lif.core_ready_o !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout got ready=%0b want 1", lif.core_ready_o);
    end
    step();
    lif.core_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    token = 1'b0;
    lif.core_valid_i = 1'b0;
    lif.core_data_i  = '0;
    step();
    checks++; if (lif.core_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b want 0", lif.core_ready_o); end
    checks++; if (lif.io_valid_o !== 1'b0) begin errors++; $display("FAIL rst_io_valid got %0b want 0", lif.io_valid_o); end
    checks++; if (lif.io_data_o !== 8'h00) begin errors++; $display("FAIL rst_io_data got %0h want 0", lif.io_data_o); end
    checks++; if (credit !== 6'd32) begin errors++; $display("FAIL rst_credit got %0d want 32", credit); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b want 0", credit_err); end
    rst_n = 1'b1;
    checks++; if (lif.core_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready_pre_edge got %0b want 0", lif.core_ready_o); end
    step();
    checks++; if (lif.core_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_rise got %0b want 1", lif.core_ready_o); end
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    do_reset();
    w = 32'hA1B2C3D4;
    send_word(w);
    checks++; if (lif.io_valid_o !== 1'b0) begin errors++; $display("FAIL single_t1_valid got %0b want 0", lif.io_valid_o); end
    for (int b = 0; b < 4; b++) begin
      step();
      checks++;
      if (lif.io_valid_o !== 1'b1 || lif.io_data_o !== w[8*b +: 8]) begin
        errors++; $display("FAIL single_beat%0d got v=%0b d=%0h want v=1 d=%0h", b, lif.io_valid_o, lif.io_data_o, w[8*b +: 8]);
      end
    end
    checks++; if (credit !== 6'd31) begin errors++; $display("FAIL single_credit got %0d want 31", credit); end
    step();
    checks++;
    if (lif.io_valid_o !== 1'b0 || lif.io_data_o !== 8'h00) begin
      errors++; $display("FAIL single_idle got v=%0b d=%0h want v=0 d=0", lif.io_valid_o, lif.io_data_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fork
      begin
        send_word(32'h03020100);
        send_word(32'h07060504);
        send_word(32'h0B0A0908);
      end
      begin
        int n = 0;
        @(negedge clk);
        while (lif.io_valid_o !== 1'b1 && n < 20) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < 12; k++) begin
          if (k > 0) @(negedge clk);
          checks++;
          if (lif.io_valid_o !== 1'b1 || lif.io_data_o !== 8'(k)) begin
            errors++; $display("FAIL b2b_beat%0d got v=%0b d=%0h want v=1 d=%0h", k, lif.io_valid_o, lif.io_data_o, k);
          end
        end
      end
    join
    step();
    step();
    checks++; if (credit !== 6'd29) begin errors++; $display("FAIL b2b_credit got %0d want 29", credit); end
    checks++; if (lif.io_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0b want 0", lif.io_valid_o); end
  endtask

  task automatic test_credit_exhaust();
    int base, n;
    logic [31:0] w;
    do_reset();
    base = beat_cnt;
    for (int i = 0; i < 33; i++) send_word(32'h10000000 + 32'(i));
    n = 0;
    while ((credit !== 6'd0 || lif.io_valid_o !== 1'b0) && n < 300) begin
      step();
      n++;
    end
    repeat (6) step();
    checks++; if (beat_cnt - base != 128) begin errors++; $display("FAIL exhaust_beats got %0d want 128", beat_cnt - base); end
    checks++; if (credit !== 6'd0) begin errors++; $display("FAIL exhaust_credit got %0d want 0", credit); end
    checks++; if (lif.io_valid_o !== 1'b0) begin errors++; $display("FAIL exhaust_held got %0b want 0", lif.io_valid_o); end
    checks++; if (lif.core_ready_o !== 1'b1) begin errors++; $display("FAIL exhaust_ready1 got %0b want 1", lif.core_ready_o); end
    lif.core_data_i  = 32'h10000021;
    lif.core_valid_i = 1'b1;
    step();
    lif.core_valid_i = 1'b0;
    checks++; if (lif.core_ready_o !== 1'b0) begin errors++; $display("FAIL exhaust_full got %0b want 0", lif.core_ready_o); end
    token = ~token;
    n = 0;
    while (lif.io_valid_o !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++; if (credit !== 6'd3) begin errors++; $display("FAIL token_credit got %0d want 3", credit); end
    checks++; if (lif.core_ready_o !== 1'b1) begin errors++; $display("FAIL token_ready got %0b want 1", lif.core_ready_o); end
    w = 32'h10000020;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) step();
      checks++;
      if (lif.io_valid_o !== 1'b1 || lif.io_data_o !== w[8*b +: 8]) begin
        errors++; $display("FAIL held_beat%0d got v=%0b d=%0h want v=1 d=%0h", b, lif.io_valid_o, lif.io_data_o, w[8*b +: 8]);
      end
    end
    step();
    checks++;
    if (lif.io_valid_o !== 1'b1 || lif.io_data_o !== 8'h21 || credit !== 6'd2) begin
      errors++; $display("FAIL next_word got v=%0b d=%0h c=%0d want v=1 d=21 c=2", lif.io_valid_o, lif.io_data_o, credit);
    end
  endtask

  task automatic test_token_same_cycle();
    int n;
    do_reset();
    for (int i = 0; i < 31; i++) send_word(32'h20000000 + 32'(i));
    n = 0;
    while ((credit !== 6'd1 || lif.io_valid_o !== 1'b0) && n < 300) begin
      step();
      n++;
    end
    step();
    checks++; if (credit !== 6'd1) begin errors++; $display("FAIL same_pre_credit got %0d want 1", credit); end
    token = ~token;
    step();
    lif.core_data_i  = 32'hCAFE00EE;
    lif.core_valid_i = 1'b1;
    step();
    lif.core_valid_i = 1'b0;
    checks++; if (lif.io_valid_o !== 1'b0) begin errors++; $display("FAIL same_not_early got %0b want 0", lif.io_valid_o); end
    step();
    checks++; if (credit !== 6'd4) begin errors++; $display("FAIL same_credit got %0d want 4", credit); end
    checks++;
    if (lif.io_valid_o !== 1'b1 || lif.io_data_o !== 8'hEE) begin
      errors++; $display("FAIL same_beat0 got v=%0b d=%0h want v=1 d=ee", lif.io_valid_o, lif.io_data_o);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    token = ~token;
    repeat (4) step();
    checks++; if (credit !== 6'd32) begin errors++; $display("FAIL ovf_credit got %0d want 32", credit); end
    checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL ovf_err got %0b want 1", credit_err); end
    repeat (5) step();
    send_word(32'h00000001);
    step();
    checks++; if (credit !== 6'd31) begin errors++; $display("FAIL ovf_after_credit got %0d want 31", credit); end
    checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", credit_err); end
  endtask

  task automatic test_reset_mid_word();
    int base;
    do_reset();
    send_word(32'h55667788);
    step();
    step();
    checks++;
    if (lif.io_valid_o !== 1'b1 || lif.io_data_o !== 8'h77) begin
      errors++; $display("FAIL mid_beat1 got v=%0b d=%0h want v=1 d=77", lif.io_valid_o, lif.io_data_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (lif.io_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid_drop got %0b want 0", lif.io_valid_o); end
    checks++; if (lif.io_data_o !== 8'h00) begin errors++; $display("FAIL mid_data got %0h want 0", lif.io_data_o); end
    checks++; if (credit !== 6'd32) begin errors++; $display("FAIL mid_credit got %0d want 32", credit); end
    checks++; if (lif.core_ready_o !== 1'b0) begin errors++; $display("FAIL mid_ready got %0b want 0", lif.core_ready_o); end
    step();
    rst_n = 1'b1;
    base = beat_cnt;
    repeat (8) step();
    checks++; if (beat_cnt != base) begin errors++; $display("FAIL mid_no_beats got %0d want 0", beat_cnt - base); end
    checks++; if (lif.core_ready_o !== 1'b1 || credit !== 6'd32) begin
      errors++; $display("FAIL mid_after got r=%0b c=%0d want r=1 c=32", lif.core_ready_o, credit);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    token = 1'b0;
    lif.core_valid_i = 1'b0;
    lif.core_data_i  = '0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_credit_exhaust();
    test_token_same_cycle();
    test_overflow();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
